// File: rtl/sram_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_bridge_pkg
// Description : Shared definitions for the Wishbone-to-async-SRAM bridge:
//               FSM state encoding and the wait-state ceiling.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_bridge_pkg;

  // Bridge FSM state encoding (2-bit, fixed values)
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    ACK    = 2'd3
  } state_t;

  // Largest supported number of extra strobe cycles
  localparam int WAIT_STATES_MAX = 15;

endpackage
`default_nettype wire

// File: rtl/sram_bridge_ws_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_bridge_ws_if
// Description : Bus bundle for sram_bridge_ws: Wishbone B4 pipelined slave
//               signals plus the split-data asynchronous SRAM pins.
//               'slave' is the bridge view, 'master' is the bus master /
//               SRAM device view.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_bridge_ws_if #(
  parameter int DW = 16,
  parameter int AW = 19
);

  // Wishbone side
  logic            cyc_i;
  logic            stb_i;
  logic            we_i;
  logic [DW/8-1:0] sel_i;
  logic [AW-1:0]   adr_i;
  logic [DW-1:0]   dat_i;
  logic            ack_o;
  logic            stall_o;
  logic [DW-1:0]   dat_o;

  // SRAM side (active-low controls, split data bus)
  logic            _sram_ce;
  logic            _sram_we;
  logic            _sram_oe;
  logic [DW/8-1:0] _sram_bs;
  logic [AW-1:0]   sram_a;
  logic [DW-1:0]   sram_d_out;
  logic            sram_d_oe;
  logic [DW-1:0]   sram_d_in;

  modport slave (
    input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, sram_d_in,
    output ack_o, stall_o, dat_o,
    output _sram_ce, _sram_we, _sram_oe, _sram_bs, sram_a, sram_d_out, sram_d_oe
  );

  modport master (
    output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, sram_d_in,
    input  ack_o, stall_o, dat_o,
    input  _sram_ce, _sram_we, _sram_oe, _sram_bs, sram_a, sram_d_out, sram_d_oe
  );

endinterface
`default_nettype wire

// File: rtl/sram_bridge_ws.sv
`default_nettype none
// ============================================================================
// Module      : sram_bridge_ws
// Description : Wishbone B4 pipelined slave to asynchronous SRAM bridge with
//               a programmable number of wait states. Every SRAM control is
//               a register output. Writes take SETUP + (WAIT_STATES+1) STROBE
//               + ACK cycles; reads take (WAIT_STATES+1) STROBE + ACK cycles.
//               Tri-state binding of the split data bus is left to the chip
//               top level.
//               Build option: define SRAM_BRIDGE_CE_GATE_EN to drive _sram_ce
//               low only while a transfer is in flight (otherwise it is tied
//               low).
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bridge_ws
  import sram_bridge_pkg::*;
#(
  parameter int DW          = 16,
  parameter int AW          = 19,
  parameter int WAIT_STATES = 0
) (
  input  logic             clk_i,
  input  logic             _reset_i,
  sram_bridge_ws_if.slave  bus
);

  // Wait states beyond the supported ceiling are clamped
  localparam int WS_EFF = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
  // Counter must be at least one bit wide even with zero wait states
  localparam int CW = (WS_EFF > 0) ? $clog2(WS_EFF + 1) : 1;
  localparam logic [CW-1:0] WS_LOAD = CW'(WS_EFF);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          is_write;
  logic          aborted;
  logic          accept;
  logic          abort_now;

  // New request is taken whenever the bridge is not stalling
  assign accept    = bus.cyc_i & bus.stb_i & ~bus.stall_o;
  // Abort is sticky: once cyc_i drops mid-transfer the ack is lost
  assign abort_now = aborted | ~bus.cyc_i;

`ifndef SRAM_BRIDGE_CE_GATE_EN
  // Chip enable permanently asserted
  assign bus._sram_ce = 1'b0;
`endif

  // Transfer FSM; all bus and SRAM outputs are registered here
  always_ff @(posedge clk_i or negedge _reset_i) begin
    if (!_reset_i) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      is_write       <= 1'b0;
      aborted        <= 1'b0;
      bus.ack_o      <= 1'b0;
      bus.stall_o    <= 1'b0;
      bus.dat_o      <= '0;
      bus._sram_we   <= 1'b1;
      bus._sram_oe   <= 1'b1;
      bus._sram_bs   <= '1;
      bus.sram_d_oe  <= 1'b0;
      bus.sram_a     <= '0;
      bus.sram_d_out <= '0;
`ifdef SRAM_BRIDGE_CE_GATE_EN
      bus._sram_ce   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE, ACK: begin
          // ack and read data live for exactly the one ACK cycle
          bus.ack_o <= 1'b0;
          bus.dat_o <= '0;
          if (accept) begin
            is_write     <= bus.we_i;
            aborted      <= 1'b0;
            bus.sram_a   <= bus.adr_i;
            bus._sram_bs <= ~bus.sel_i;
            bus.stall_o  <= 1'b1;
`ifdef SRAM_BRIDGE_CE_GATE_EN
            bus._sram_ce <= 1'b0;
`endif
            if (bus.we_i) begin
              // Data is driven one cycle before the write strobe
              state          <= SETUP;
              bus.sram_d_out <= bus.dat_i;
              bus.sram_d_oe  <= 1'b1;
            end else begin
              state          <= STROBE;
              wait_cnt       <= WS_LOAD;
              bus._sram_oe   <= 1'b0;
              bus.sram_d_out <= '0;
              bus.sram_d_oe  <= 1'b0;
            end
          end else begin
            state         <= IDLE;
            bus.stall_o   <= 1'b0;
            bus._sram_bs  <= '1;
            bus.sram_d_oe <= 1'b0;
`ifdef SRAM_BRIDGE_CE_GATE_EN
            bus._sram_ce  <= 1'b1;
`endif
          end
        end

        SETUP: begin
          aborted      <= abort_now;
          state        <= STROBE;
          wait_cnt     <= WS_LOAD;
          bus._sram_we <= 1'b0;
        end

        STROBE: begin
          aborted <= abort_now;
          if (wait_cnt == '0) begin
            // Strobes release together; write data stays driven as hold time
            state        <= ACK;
            bus._sram_we <= 1'b1;
            bus._sram_oe <= 1'b1;
            bus.stall_o  <= 1'b0;
            bus.ack_o    <= ~abort_now;
            if (!is_write && !abort_now) begin
              bus.dat_o <= bus.sram_d_in;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_bridge_ws.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_bridge_ws
// Description : Directed self-checking bench for sram_bridge_ws. One 16-bit
//               instance with two wait states and one 8-bit instance with
//               none; expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bridge_ws;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d;
  logic rst_e;
  logic use_fixed;

  sram_bridge_ws_if #(.DW(16), .AW(19)) bd ();
  sram_bridge_ws_if #(.DW(8),  .AW(19)) be ();

  sram_bridge_ws #(.DW(16), .AW(19), .WAIT_STATES(2)) dut_d (
    .clk_i    (clk),
    ._reset_i (rst_d),
    .bus      (bd.slave)
  );

  sram_bridge_ws #(.DW(8), .AW(19), .WAIT_STATES(0)) dut_e (
    .clk_i    (clk),
    ._reset_i (rst_e),
    .bus      (be.slave)
  );

  // Simple SRAM models: data is a fixed function of the address
  assign bd.sram_d_in = use_fixed ? 16'hF00D : {8'hA0, bd.sram_a[7:0]};
  assign be.sram_d_in = {be.sram_a[3:0], 4'h6};

`ifdef SRAM_BRIDGE_CE_GATE_EN
  localparam logic CE_IDLE = 1'b1;
`else
  localparam logic CE_IDLE = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-transaction observations
  int          oe_lo, we_lo, acks, ack_at, doe_cnt, ce_bad, dat_bad;
  logic [15:0] rdat;
  logic [1:0]  bs_seen;
  logic [18:0] a_seen;

  // One transfer on the 16-bit bridge, observed for 10 cycles; cyc_i is
  // dropped at cycle drop_at (0 = never)
  task automatic txn_d(input logic we, input logic [18:0] adr, input logic [15:0] dat,
                       input logic [1:0] sel, input int drop_at);
    oe_lo = 0; we_lo = 0; acks = 0; ack_at = 0; doe_cnt = 0; ce_bad = 0; dat_bad = 0;
    rdat = '0; bs_seen = '0; a_seen = '0;
    bd.cyc_i = 1'b1; bd.stb_i = 1'b1; bd.we_i = we;
    bd.adr_i = adr;  bd.dat_i = dat;  bd.sel_i = sel;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bd.stb_i = 1'b0;
        bs_seen  = bd._sram_bs;
        a_seen   = bd.sram_a;
      end
      if (i == drop_at) bd.cyc_i = 1'b0;
      if (!bd._sram_oe) oe_lo++;
      if (!bd._sram_we) begin
        we_lo++;
        if (bd.sram_d_out !== dat || bd.sram_d_oe !== 1'b1) dat_bad++;
      end
      if (bd.sram_d_oe) doe_cnt++;
      if (bd.ack_o) begin
        acks++;
        ack_at = i;
        rdat   = bd.dat_o;
      end else if (bd.dat_o !== 16'h0) begin
        dat_bad++;
      end
      if (bd.stall_o && bd._sram_ce !== 1'b0) ce_bad++;
    end
    bd.cyc_i = 1'b0;
  endtask

  // Same for the 8-bit zero-wait-state bridge, observed for 6 cycles
  task automatic txn_e(input logic we, input logic [18:0] adr, input logic [7:0] dat,
                       input logic sel);
    oe_lo = 0; we_lo = 0; acks = 0; ack_at = 0; ce_bad = 0;
    rdat = '0; bs_seen = '0;
    be.cyc_i = 1'b1; be.stb_i = 1'b1; be.we_i = we;
    be.adr_i = adr;  be.dat_i = dat;  be.sel_i = sel;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) begin
        be.stb_i = 1'b0;
        bs_seen  = {1'b0, be._sram_bs};
      end
      if (!be._sram_oe) oe_lo++;
      if (!be._sram_we) we_lo++;
      if (be.ack_o) begin
        acks++;
        ack_at = i;
        rdat   = {8'h00, be.dat_o};
      end
      if (be.stall_o && be._sram_ce !== 1'b0) ce_bad++;
    end
    be.cyc_i = 1'b0;
  endtask

  int n_iss, n_ack, first_ack, last_ack, stall_hi, post_acks;
  logic prev_acc;

  initial begin
    rst_d = 1'b0; rst_e = 1'b0; use_fixed = 1'b0;
    bd.cyc_i = 1'b0; bd.stb_i = 1'b0; bd.we_i = 1'b0; bd.sel_i = '0; bd.adr_i = '0; bd.dat_i = '0;
    be.cyc_i = 1'b0; be.stb_i = 1'b0; be.we_i = 1'b0; be.sel_i = '0; be.adr_i = '0; be.dat_i = '0;
    repeat (3) @(negedge clk);

    // Values held during reset
    check_eq("rst_ack",   bd.ack_o,      0);
    check_eq("rst_stall", bd.stall_o,    0);
    check_eq("rst_dat_o", bd.dat_o,      0);
    check_eq("rst_we_n",  bd._sram_we,   1);
    check_eq("rst_oe_n",  bd._sram_oe,   1);
    check_eq("rst_bs_n",  bd._sram_bs,   2'b11);
    check_eq("rst_d_oe",  bd.sram_d_oe,  0);
    check_eq("rst_addr",  bd.sram_a,     0);
    check_eq("rst_d_out", bd.sram_d_out, 0);
    check_eq("rst_ce_n",  bd._sram_ce,   CE_IDLE);

    rst_d = 1'b1; rst_e = 1'b1;
    @(negedge clk);

    // Read, fixed data: three strobe cycles then ack
    use_fixed = 1'b1;
    txn_d(1'b0, 19'h00003, 16'h0000, 2'b11, 0);
    check_eq("rd_oe_cycles", oe_lo, 3);
    check_eq("rd_we_cycles", we_lo, 0);
    check_eq("rd_acks",      acks, 1);
    check_eq("rd_ack_at",    ack_at, 4);
    check_eq("rd_data",      rdat, 16'hF00D);
    check_eq("rd_dat_zero",  dat_bad, 0);
    check_eq("rd_addr",      a_seen, 19'h00003);
    check_eq("rd_bs",        bs_seen, 2'b00);
    check_eq("rd_ce_busy",   ce_bad, 0);
    use_fixed = 1'b0;

    // Write, upper lane only: setup + three strobes + ack
    txn_d(1'b1, 19'h00010, 16'hBEEF, 2'b10, 0);
    check_eq("wr_we_cycles", we_lo, 3);
    check_eq("wr_oe_cycles", oe_lo, 0);
    check_eq("wr_acks",      acks, 1);
    check_eq("wr_ack_at",    ack_at, 5);
    check_eq("wr_bs",        bs_seen, 2'b01);
    check_eq("wr_doe_cycles", doe_cnt, 5);
    check_eq("wr_dat_o_zero", rdat, 0);
    check_eq("wr_data_bus",  dat_bad, 0);
    check_eq("wr_addr",      a_seen, 19'h00010);
    check_eq("idle_ce_n",    bd._sram_ce, CE_IDLE);
    check_eq("idle_bs_n",    bd._sram_bs, 2'b11);
    check_eq("idle_d_oe",    bd.sram_d_oe, 0);

    // Write with no byte lanes: full bus cycle, lanes off, still acked
    txn_d(1'b1, 19'h00011, 16'h1234, 2'b00, 0);
    check_eq("sel0_bs",   bs_seen, 2'b11);
    check_eq("sel0_we",   we_lo, 3);
    check_eq("sel0_acks", acks, 1);

    // Read aborted in the second strobe cycle: timing completes, no ack
    txn_d(1'b0, 19'h00020, 16'h0000, 2'b11, 2);
    check_eq("abt_oe_cycles", oe_lo, 3);
    check_eq("abt_acks",      acks, 0);
    check_eq("abt_state",     dut_d.state, 0);
    check_eq("abt_stall",     bd.stall_o, 0);

    // Back-to-back reads with stb held: one issue per four cycles
    bd.cyc_i = 1'b1; bd.stb_i = 1'b1; bd.we_i = 1'b0; bd.sel_i = 2'b11; bd.adr_i = 19'h40;
    n_iss = 0; n_ack = 0; first_ack = -1; last_ack = -1; stall_hi = 0;
    prev_acc = bd.stb_i & ~bd.stall_o;
    for (int c = 0; c < 40 && n_ack < 4; c++) begin
      @(negedge clk);
      if (c < 16 && bd.stall_o) stall_hi++;
      if (bd.ack_o) begin
        check_eq("b2b_data", bd.dat_o, {8'hA0, 8'(8'h40 + n_ack)});
        if (first_ack < 0) first_ack = c;
        last_ack = c;
        n_ack++;
      end
      if (prev_acc) begin
        n_iss++;
        if (n_iss == 4) bd.stb_i = 1'b0;
        else            bd.adr_i = 19'h40 + 19'(n_iss);
      end
      prev_acc = bd.stb_i & ~bd.stall_o;
    end
    bd.cyc_i = 1'b0; bd.stb_i = 1'b0;
    check_eq("b2b_acks",     n_ack, 4);
    check_eq("b2b_first",    first_ack, 3);
    check_eq("b2b_span",     last_ack - first_ack, 12);
    check_eq("b2b_stall_hi", stall_hi, 12);
    @(negedge clk);

    // Reset pulse during write strobe: controls release at once, no ack
    bd.cyc_i = 1'b1; bd.stb_i = 1'b1; bd.we_i = 1'b1; bd.adr_i = 19'h55;
    bd.dat_i = 16'hCAFE; bd.sel_i = 2'b11;
    @(negedge clk);
    bd.stb_i = 1'b0;
    @(negedge clk);
    check_eq("rstmid_pre_we", bd._sram_we, 0);
    #2 rst_d = 1'b0;
    #1;
    check_eq("rstmid_we_n",  bd._sram_we, 1);
    check_eq("rstmid_d_oe",  bd.sram_d_oe, 0);
    check_eq("rstmid_stall", bd.stall_o, 0);
    check_eq("rstmid_bs_n",  bd._sram_bs, 2'b11);
    @(negedge clk);
    rst_d = 1'b1;
    bd.cyc_i = 1'b0;
    post_acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bd.ack_o) post_acks++;
    end
    check_eq("rstmid_no_ack", post_acks, 0);
    txn_d(1'b0, 19'h00022, 16'h0000, 2'b11, 0);
    check_eq("rstmid_next_ack",  acks, 1);
    check_eq("rstmid_next_data", rdat, 16'hA022);

    // 8-bit, zero wait states
    txn_e(1'b1, 19'h00005, 8'h3C, 1'b1);
    check_eq("e_wr_we_cycles", we_lo, 1);
    check_eq("e_wr_ack_at",    ack_at, 3);
    check_eq("e_wr_bs",        bs_seen, 2'b00);
    check_eq("e_wr_ce_busy",   ce_bad, 0);
    txn_e(1'b0, 19'h00009, 8'h00, 1'b1);
    check_eq("e_rd_oe_cycles", oe_lo, 1);
    check_eq("e_rd_acks",      acks, 1);
    check_eq("e_rd_ack_at",    ack_at, 2);
    check_eq("e_rd_data",      rdat, 16'h0096);
    txn_e(1'b1, 19'h00006, 8'h11, 1'b0);
    check_eq("e_sel0_bs",      bs_seen, 2'b01);
    check_eq("e_sel0_acks",    acks, 1);
    check_eq("e_idle_ce_n",    be._sram_ce, CE_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
